bus_arbiter_2to1: RTL and testbench

Shares one downstream composite bus port between two upstream requesters. The port has five valid/ready channels: addr_read, addr_write, data_write, data_read and resp_write. The block sits between two side_a-type masters and a single side_b-type slave. It arbitrates round-robin at transaction granularity and allows one outstanding transaction at a time. It multiplexes every channel of the granted requester and blocks the other requester completely.

---
 rtl/bus_arbiter_2to1_pkg.sv | 18 +
 rtl/bus_arbiter_2to1_rr_pick2.sv | 15 +
 rtl/bus_arbiter_2to1.sv | 208 ++++++++++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared types and defaults for the two-requester composite bus arbiter.
package bus_arbiter_2to1_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Encoding doubles as the request index fed to rr_pick2 for op selection.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/bus_arbiter_2to1_rr_pick2.sv
// Two-input round-robin pick: a lone request wins, a tie goes to the side not picked last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 arbiter for a five-channel valid/ready bus, one transaction in flight.
module bus_arbiter_2to1
    import bus_arbiter_2to1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] m0_addr_read_bus_data,
    input  logic                  m0_addr_read_bus_valid,
    output logic                  m0_addr_read_bus_ready,
    input  logic [DATA_WIDTH-1:0] m0_addr_write_bus_data,
    input  logic                  m0_addr_write_bus_valid,
    output logic                  m0_addr_write_bus_ready,
    input  logic [DATA_WIDTH-1:0] m0_data_write_bus_data,
    input  logic                  m0_data_write_bus_valid,
    output logic                  m0_data_write_bus_ready,
    output logic [DATA_WIDTH-1:0] m0_data_read_bus_data,
    output logic                  m0_data_read_bus_valid,
    input  logic                  m0_data_read_bus_ready,
    output logic [DATA_WIDTH-1:0] m0_resp_write_bus_data,
    output logic                  m0_resp_write_bus_valid,
    input  logic                  m0_resp_write_bus_ready,

    input  logic [DATA_WIDTH-1:0] m1_addr_read_bus_data,
    input  logic                  m1_addr_read_bus_valid,
    output logic                  m1_addr_read_bus_ready,
    input  logic [DATA_WIDTH-1:0] m1_addr_write_bus_data,
    input  logic                  m1_addr_write_bus_valid,
    output logic                  m1_addr_write_bus_ready,
    input  logic [DATA_WIDTH-1:0] m1_data_write_bus_data,
    input  logic                  m1_data_write_bus_valid,
    output logic                  m1_data_write_bus_ready,
    output logic [DATA_WIDTH-1:0] m1_data_read_bus_data,
    output logic                  m1_data_read_bus_valid,
    input  logic                  m1_data_read_bus_ready,
    output logic [DATA_WIDTH-1:0] m1_resp_write_bus_data,
    output logic                  m1_resp_write_bus_valid,
    input  logic                  m1_resp_write_bus_ready,

    output logic [DATA_WIDTH-1:0] s_addr_read_bus_data,
    output logic                  s_addr_read_bus_valid,
    input  logic                  s_addr_read_bus_ready,
    output logic [DATA_WIDTH-1:0] s_addr_write_bus_data,
    output logic                  s_addr_write_bus_valid,
    input  logic                  s_addr_write_bus_ready,
    output logic [DATA_WIDTH-1:0] s_data_write_bus_data,
    output logic                  s_data_write_bus_valid,
    input  logic                  s_data_write_bus_ready,
    input  logic [DATA_WIDTH-1:0] s_data_read_bus_data,
    input  logic                  s_data_read_bus_valid,
    output logic                  s_data_read_bus_ready,
    input  logic [DATA_WIDTH-1:0] s_resp_write_bus_data,
    input  logic                  s_resp_write_bus_valid,
    output logic                  s_resp_write_bus_ready,

    output logic [1:0]            grant,
    output logic                  busy
);

    state_t     state;
    op_t        last_op;
    op_t        sel_op;
    logic       owner;
    logic       last_owner;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;
    logic [1:0] cand;
    logic [1:0] owner_pick;
    logic [1:0] op_req;
    logic [1:0] op_pick;
    logic       sel_owner;
    logic       fwd_ar;
    logic       fwd_dr;
    logic       fwd_aw;
    logic       fwd_w;
    logic       fwd_b;
    logic       ar_hs;
    logic       aw_hs;
    logic       w_hs;
    logic       dr_hs;
    logic       b_hs;

    // Arbitration: pick the owner first, then the op among that owner's address valids.
    assign cand = {m1_addr_read_bus_valid | m1_addr_write_bus_valid,
                   m0_addr_read_bus_valid | m0_addr_write_bus_valid};

    rr_pick2 u_owner_pick (
        .req  (cand),
        .last (last_owner),
        .pick (owner_pick)
    );

    assign sel_owner = owner_pick[1];
    assign op_req    = sel_owner ? {m1_addr_write_bus_valid, m1_addr_read_bus_valid}
                                 : {m0_addr_write_bus_valid, m0_addr_read_bus_valid};

    rr_pick2 u_op_pick (
        .req  (op_req),
        .last (last_op == OP_WRITE),
        .pick (op_pick)
    );

    assign sel_op = op_t'(op_pick[1]);

    assign fwd_ar = (state == ST_READ)  && !ar_done;
    assign fwd_dr = (state == ST_READ)  &&  ar_done;
    assign fwd_aw = (state == ST_WRITE) && !aw_done;
    assign fwd_w  = (state == ST_WRITE) && !w_done;
    assign fwd_b  = (state == ST_WRITE) &&  aw_done && w_done;

    assign ar_hs = s_addr_read_bus_valid  && s_addr_read_bus_ready;
    assign aw_hs = s_addr_write_bus_valid && s_addr_write_bus_ready;
    assign w_hs  = s_data_write_bus_valid && s_data_write_bus_ready;
    assign dr_hs = s_data_read_bus_valid  && s_data_read_bus_ready;
    assign b_hs  = s_resp_write_bus_valid && s_resp_write_bus_ready;

    // Requester-to-slave channels.
    assign s_addr_read_bus_valid  = fwd_ar && (owner ? m1_addr_read_bus_valid : m0_addr_read_bus_valid);
    assign s_addr_read_bus_data   = fwd_ar ? (owner ? m1_addr_read_bus_data : m0_addr_read_bus_data) : '0;
    assign m0_addr_read_bus_ready = fwd_ar && !owner && s_addr_read_bus_ready;
    assign m1_addr_read_bus_ready = fwd_ar &&  owner && s_addr_read_bus_ready;

    assign s_addr_write_bus_valid  = fwd_aw && (owner ? m1_addr_write_bus_valid : m0_addr_write_bus_valid);
    assign s_addr_write_bus_data   = fwd_aw ? (owner ? m1_addr_write_bus_data : m0_addr_write_bus_data) : '0;
    assign m0_addr_write_bus_ready = fwd_aw && !owner && s_addr_write_bus_ready;
    assign m1_addr_write_bus_ready = fwd_aw &&  owner && s_addr_write_bus_ready;

    assign s_data_write_bus_valid  = fwd_w && (owner ? m1_data_write_bus_valid : m0_data_write_bus_valid);
    assign s_data_write_bus_data   = fwd_w ? (owner ? m1_data_write_bus_data : m0_data_write_bus_data) : '0;
    assign m0_data_write_bus_ready = fwd_w && !owner && s_data_write_bus_ready;
    assign m1_data_write_bus_ready = fwd_w &&  owner && s_data_write_bus_ready;

    // Slave-to-requester channels; unexpected slave valids see ready=0.
    assign s_data_read_bus_ready  = fwd_dr && (owner ? m1_data_read_bus_ready : m0_data_read_bus_ready);
    assign m0_data_read_bus_valid = fwd_dr && !owner && s_data_read_bus_valid;
    assign m1_data_read_bus_valid = fwd_dr &&  owner && s_data_read_bus_valid;
    assign m0_data_read_bus_data  = (fwd_dr && !owner) ? s_data_read_bus_data : '0;
    assign m1_data_read_bus_data  = (fwd_dr &&  owner) ? s_data_read_bus_data : '0;

    assign s_resp_write_bus_ready  = fwd_b && (owner ? m1_resp_write_bus_ready : m0_resp_write_bus_ready);
    assign m0_resp_write_bus_valid = fwd_b && !owner && s_resp_write_bus_valid;
    assign m1_resp_write_bus_valid = fwd_b &&  owner && s_resp_write_bus_valid;
    assign m0_resp_write_bus_data  = (fwd_b && !owner) ? s_resp_write_bus_data : '0;
    assign m1_resp_write_bus_data  = (fwd_b &&  owner) ? s_resp_write_bus_data : '0;

    // Transaction FSM; reset leaves m0 winning the first tie and read winning the first op tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            last_op    <= OP_WRITE;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|cand) begin
                        state      <= (sel_op == OP_WRITE) ? ST_WRITE : ST_READ;
                        owner      <= sel_owner;
                        last_owner <= sel_owner;
                        last_op    <= sel_op;
                        ar_done    <= 1'b0;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        grant      <= owner_pick;
                        busy       <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                    if (dr_hs) begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                        busy  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: transaction table, scoreboard queues, corner sequences.
module tb_bus_arbiter_2to1;

    logic       clk;
    logic       rst_n;

    logic [7:0] m0_ar_d, m0_aw_d, m0_w_d, m0_dr_d, m0_b_d;
    logic       m0_ar_v, m0_ar_r, m0_aw_v, m0_aw_r, m0_w_v, m0_w_r;
    logic       m0_dr_v, m0_dr_r, m0_b_v, m0_b_r;
    logic [7:0] m1_ar_d, m1_aw_d, m1_w_d, m1_dr_d, m1_b_d;
    logic       m1_ar_v, m1_ar_r, m1_aw_v, m1_aw_r, m1_w_v, m1_w_r;
    logic       m1_dr_v, m1_dr_r, m1_b_v, m1_b_r;
    logic [7:0] s_ar_d, s_aw_d, s_w_d, s_dr_d, s_b_d;
    logic       s_ar_v, s_ar_r, s_aw_v, s_aw_r, s_w_v, s_w_r;
    logic       s_dr_v, s_dr_r, s_b_v, s_b_r;
    logic [1:0] grant;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_ar[$];
    logic [7:0] q_aw[$];
    logic [7:0] q_w[$];
    logic [8:0] q_rd[$];
    logic [8:0] q_b[$];

    logic [17:0] out_ctl;
    logic        any_data;

    assign out_ctl  = {s_ar_v, s_aw_v, s_w_v, s_dr_r, s_b_r,
                       m0_ar_r, m0_aw_r, m0_w_r, m0_dr_v, m0_b_v,
                       m1_ar_r, m1_aw_r, m1_w_r, m1_dr_v, m1_b_v, grant, busy};
    assign any_data = |{s_ar_d, s_aw_d, s_w_d, m0_dr_d, m0_b_d, m1_dr_d, m1_b_d};

    bus_arbiter_2to1 #(.DATA_WIDTH(8)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .m0_addr_read_bus_data   (m0_ar_d),
        .m0_addr_read_bus_valid  (m0_ar_v),
        .m0_addr_read_bus_ready  (m0_ar_r),
        .m0_addr_write_bus_data  (m0_aw_d),
        .m0_addr_write_bus_valid (m0_aw_v),
        .m0_addr_write_bus_ready (m0_aw_r),
        .m0_data_write_bus_data  (m0_w_d),
        .m0_data_write_bus_valid (m0_w_v),
        .m0_data_write_bus_ready (m0_w_r),
        .m0_data_read_bus_data   (m0_dr_d),
        .m0_data_read_bus_valid  (m0_dr_v),
        .m0_data_read_bus_ready  (m0_dr_r),
        .m0_resp_write_bus_data  (m0_b_d),
        .m0_resp_write_bus_valid (m0_b_v),
        .m0_resp_write_bus_ready (m0_b_r),
        .m1_addr_read_bus_data   (m1_ar_d),
        .m1_addr_read_bus_valid  (m1_ar_v),
        .m1_addr_read_bus_ready  (m1_ar_r),
        .m1_addr_write_bus_data  (m1_aw_d),
        .m1_addr_write_bus_valid (m1_aw_v),
        .m1_addr_write_bus_ready (m1_aw_r),
        .m1_data_write_bus_data  (m1_w_d),
        .m1_data_write_bus_valid (m1_w_v),
        .m1_data_write_bus_ready (m1_w_r),
        .m1_data_read_bus_data   (m1_dr_d),
        .m1_data_read_bus_valid  (m1_dr_v),
        .m1_data_read_bus_ready  (m1_dr_r),
        .m1_resp_write_bus_data  (m1_b_d),
        .m1_resp_write_bus_valid (m1_b_v),
        .m1_resp_write_bus_ready (m1_b_r),
        .s_addr_read_bus_data    (s_ar_d),
        .s_addr_read_bus_valid   (s_ar_v),
        .s_addr_read_bus_ready   (s_ar_r),
        .s_addr_write_bus_data   (s_aw_d),
        .s_addr_write_bus_valid  (s_aw_v),
        .s_addr_write_bus_ready  (s_aw_r),
        .s_data_write_bus_data   (s_w_d),
        .s_data_write_bus_valid  (s_w_v),
        .s_data_write_bus_ready  (s_w_r),
        .s_data_read_bus_data    (s_dr_d),
        .s_data_read_bus_valid   (s_dr_v),
        .s_data_read_bus_ready   (s_dr_r),
        .s_resp_write_bus_data   (s_b_d),
        .s_resp_write_bus_valid  (s_b_v),
        .s_resp_write_bus_ready  (s_b_r),
        .grant                   (grant),
        .busy                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshake on a monitored channel pops its expected value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_ar_v && s_ar_r) begin
                if (q_ar.size() == 0) check("sb_ar_unexpected", 32'(s_ar_d), 32'hFFFF);
                else check("sb_ar", 32'(s_ar_d), 32'(q_ar.pop_front()));
            end
            if (s_aw_v && s_aw_r) begin
                if (q_aw.size() == 0) check("sb_aw_unexpected", 32'(s_aw_d), 32'hFFFF);
                else check("sb_aw", 32'(s_aw_d), 32'(q_aw.pop_front()));
            end
            if (s_w_v && s_w_r) begin
                if (q_w.size() == 0) check("sb_w_unexpected", 32'(s_w_d), 32'hFFFF);
                else check("sb_w", 32'(s_w_d), 32'(q_w.pop_front()));
            end
            if (m0_dr_v && m0_dr_r) begin
                if (q_rd.size() == 0) check("sb_rd_unexpected", 32'({1'b0, m0_dr_d}), 32'hFFFF);
                else check("sb_rd", 32'({1'b0, m0_dr_d}), 32'(q_rd.pop_front()));
            end
            if (m1_dr_v && m1_dr_r) begin
                if (q_rd.size() == 0) check("sb_rd_unexpected", 32'({1'b1, m1_dr_d}), 32'hFFFF);
                else check("sb_rd", 32'({1'b1, m1_dr_d}), 32'(q_rd.pop_front()));
            end
            if (m0_b_v && m0_b_r) begin
                if (q_b.size() == 0) check("sb_b_unexpected", 32'({1'b0, m0_b_d}), 32'hFFFF);
                else check("sb_b", 32'({1'b0, m0_b_d}), 32'(q_b.pop_front()));
            end
            if (m1_b_v && m1_b_r) begin
                if (q_b.size() == 0) check("sb_b_unexpected", 32'({1'b1, m1_b_d}), 32'hFFFF);
                else check("sb_b", 32'({1'b1, m1_b_d}), 32'(q_b.pop_front()));
            end
        end
    end

    typedef struct {
        int         m;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         ar_dly;
        int         aw_dly;
        int         w_dly;
        logic       exp_wr;
    } txn_t;

    txn_t tbl[7];

    task automatic drive_master(input int m, input logic arv, input logic [7:0] ard,
                                input logic awv, input logic [7:0] awd,
                                input logic wv, input logic [7:0] wd,
                                input logic drr, input logic br);
        if (m == 0) begin
            m0_ar_v = arv; m0_ar_d = ard; m0_aw_v = awv; m0_aw_d = awd;
            m0_w_v = wv; m0_w_d = wd; m0_dr_r = drr; m0_b_r = br;
        end else begin
            m1_ar_v = arv; m1_ar_d = ard; m1_aw_v = awv; m1_aw_d = awd;
            m1_w_v = wv; m1_w_d = wd; m1_dr_r = drr; m1_b_r = br;
        end
    endtask

    task automatic clear_inputs();
        drive_master(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        drive_master(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        s_ar_r = 1'b0; s_aw_r = 1'b0; s_w_r = 1'b0;
        s_dr_v = 1'b0; s_dr_d = 8'h00; s_b_v = 1'b0; s_b_d = 8'h00;
    endtask

    function automatic logic [4:0] quiet_bits(input int m);
        return (m == 0) ? {m0_ar_r, m0_aw_r, m0_w_r, m0_dr_v, m0_b_v}
                        : {m1_ar_r, m1_aw_r, m1_w_r, m1_dr_v, m1_b_v};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        q_ar.delete(); q_aw.delete(); q_w.delete(); q_rd.delete(); q_b.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl_held", 32'(out_ctl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ctl", 32'(out_ctl), 32'h0);
        check("reset_data", 32'(any_data), 32'h0);
    endtask

    // One transaction with the given slave ready delays; the slave offers its return
    // beat from the start so premature forwarding is visible.
    task automatic run_txn(input txn_t t);
        logic ar_hs, aw_hs, w_hs, ret_hs, a_done, aw_d, w_d, fin;
        int   k;
        @(posedge clk); #1;
        drive_master(t.m, t.rd, t.addr, t.wr, t.addr, t.wr, t.wdata, 1'b1, 1'b1);
        s_ar_r = 1'b0; s_aw_r = 1'b0; s_w_r = 1'b0;
        s_dr_v = !t.exp_wr; s_dr_d = t.rdata;
        s_b_v  =  t.exp_wr; s_b_d  = t.rdata;
        if (t.exp_wr) begin
            q_aw.push_back(t.addr);
            q_w.push_back(t.wdata);
            q_b.push_back({1'(t.m), t.rdata});
        end else begin
            q_ar.push_back(t.addr);
            q_rd.push_back({1'(t.m), t.rdata});
        end
        @(negedge clk);
        check("arb_idle_grant", 32'(grant), 32'h0);
        a_done = 1'b0; aw_d = 1'b0; w_d = 1'b0; fin = 1'b0; k = 0;
        @(posedge clk); #1;
        while (!fin && k < 40) begin
            s_ar_r = (k >= t.ar_dly);
            s_aw_r = (k >= t.aw_dly);
            s_w_r  = (k >= t.w_dly);
            @(negedge clk);
            if (k == 0) begin
                check("arb_grant", 32'(grant), (t.m == 0) ? 32'h1 : 32'h2);
                check("arb_busy", 32'(busy), 32'h1);
                check("arb_latency", 32'(t.exp_wr ? s_aw_v : s_ar_v), 32'h1);
            end
            check("nonowner_quiet", 32'(quiet_bits(1 - t.m)), 32'h0);
            if (t.exp_wr) begin
                check("wr_other_op", 32'(s_ar_v), 32'h0);
                if (!(aw_d && w_d)) check("resp_gated", 32'({s_b_r, m0_b_v, m1_b_v}), 32'h0);
            end else begin
                check("rd_other_op", 32'({s_aw_v, s_w_v}), 32'h0);
                if (!a_done) check("rdata_gated", 32'({s_dr_r, m0_dr_v, m1_dr_v}), 32'h0);
            end
            ar_hs  = s_ar_v && s_ar_r;
            aw_hs  = s_aw_v && s_aw_r;
            w_hs   = s_w_v && s_w_r;
            ret_hs = (s_dr_v && s_dr_r) || (s_b_v && s_b_r);
            @(posedge clk); #1;
            if (ar_hs) begin
                a_done = 1'b1;
                if (t.m == 0) m0_ar_v = 1'b0; else m1_ar_v = 1'b0;
            end
            if (aw_hs) begin
                aw_d = 1'b1;
                if (t.m == 0) m0_aw_v = 1'b0; else m1_aw_v = 1'b0;
            end
            if (w_hs) begin
                w_d = 1'b1;
                if (t.m == 0) m0_w_v = 1'b0; else m1_w_v = 1'b0;
            end
            if (ret_hs) fin = 1'b1;
            k++;
        end
        check("txn_done", 32'(fin), 32'h1);
        clear_inputs();
        @(negedge clk);
        check("busy_drop", 32'({busy, grant}), 32'h0);
    endtask

    logic [1:0] exp_g [7];
    logic       hs0, hs1;

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        //          m  rd    wr    addr   wdata  rdata  ar aw w  exp_wr
        tbl[0] = '{0, 1'b1, 1'b0, 8'h12, 8'h00, 8'h5A, 0, 0, 0, 1'b0};
        tbl[1] = '{1, 1'b0, 1'b1, 8'h34, 8'hC3, 8'h01, 0, 3, 0, 1'b1};
        tbl[2] = '{0, 1'b1, 1'b1, 8'h56, 8'h11, 8'h77, 0, 0, 0, 1'b0};
        tbl[3] = '{0, 1'b1, 1'b1, 8'h78, 8'h22, 8'h02, 0, 0, 0, 1'b1};
        tbl[4] = '{1, 1'b1, 1'b0, 8'h9A, 8'h00, 8'hA5, 2, 0, 0, 1'b0};
        tbl[5] = '{0, 1'b0, 1'b1, 8'hBC, 8'h33, 8'h03, 0, 0, 2, 1'b1};
        tbl[6] = '{1, 1'b0, 1'b1, 8'hDE, 8'h44, 8'h04, 0, 1, 1, 1'b1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
        end

        // Simultaneous reads after reset: m0 first, m1 in the following IDLE cycle.
        do_reset();
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        @(posedge clk); #1;
        drive_master(0, 1'b1, 8'h21, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        drive_master(1, 1'b1, 8'h43, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        s_ar_r = 1'b1; s_dr_v = 1'b1; s_dr_d = 8'h66;
        q_ar.push_back(8'h21); q_ar.push_back(8'h43);
        q_rd.push_back({1'b0, 8'h66}); q_rd.push_back({1'b1, 8'h66});
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("tie_grant", 32'(grant), 32'(exp_g[c]));
            if (grant == 2'b01) check("tie_m1_blocked", 32'(quiet_bits(1)), 32'h0);
            hs0 = m0_ar_v && m0_ar_r;
            hs1 = m1_ar_v && m1_ar_r;
            @(posedge clk); #1;
            if (hs0) m0_ar_v = 1'b0;
            if (hs1) m1_ar_v = 1'b0;
        end
        clear_inputs();

        // Stray slave return beats while idle are held off.
        @(posedge clk); #1;
        drive_master(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        drive_master(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        s_dr_v = 1'b1; s_dr_d = 8'hEE; s_b_v = 1'b1; s_b_d = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("stray_hold", 32'({s_dr_r, s_b_r, m0_dr_v, m1_dr_v, m0_b_v, m1_b_v, busy}), 32'h0);
        end
        clear_inputs();

        // Reset mid-write after the address handshake aborts everything at once.
        @(posedge clk); #1;
        drive_master(0, 1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, 8'h6D, 1'b1, 1'b1);
        s_aw_r = 1'b1;
        q_aw.push_back(8'h5C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_aw_v = 1'b0;
        @(negedge clk);
        check("pre_reset_w_fwd", 32'({s_aw_v, s_w_v, busy}), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_abort_ctl", 32'(out_ctl), 32'h0);
        check("reset_abort_data", 32'(any_data), 32'h0);
        clear_inputs();
        q_w.delete(); q_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn('{1, 1'b1, 1'b0, 8'h0F, 8'h00, 8'hF0, 0, 0, 0, 1'b0});

        check("sb_drained", 32'(q_ar.size() + q_aw.size() + q_w.size() + q_rd.size() + q_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
